// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one combinational-read memory port between an
// instruction-fetch requester and a load/store requester. Data has priority,
// but fetch is forced through after STARVE_MAX consecutive denials. Data
// requests that are misaligned or outside the memory window are still
// granted. For those requests the memory is not touched and the response
// reports an error. Every transfer gets its response exactly one cycle later.

module mem_arbiter #(
    parameter int unsigned       AWIDTH     = 32,
    parameter int unsigned       DWIDTH     = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR  = 32'h01000000,
    parameter logic [AWIDTH-1:0] MEM_BYTES  = 32'h00100000,
    parameter int unsigned       STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    input  logic [2:0]        d_funct3_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    output logic              d_err_o,

    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic [2:0]        mem_funct3_o,
    output logic              mem_ren_o,
    output logic              mem_wen_o,
    input  logic [DWIDTH-1:0] mem_rdata_i,

    output logic [15:0]       if_stall_cnt_o
);

    localparam int unsigned       SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [AWIDTH:0]   BASE_EXT   = {1'b0, BASE_ADDR};
    localparam logic [AWIDTH:0]   END_EXT    = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES};

    logic              ready_q,     ready_d;
    logic [SW-1:0]     starve_q,    starve_d;
    logic [15:0]       stall_q,     stall_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [DWIDTH-1:0] if_rdata_q,  if_rdata_d;
    logic              d_rvalid_q,  d_rvalid_d;
    logic              d_err_q,     d_err_d;
    logic [DWIDTH-1:0] d_rdata_q,   d_rdata_d;

    logic              fetch_win;
    logic              data_win;
    logic              if_addr_x;
    logic              d_addr_x;
    logic              misaligned;
    logic              out_of_range;
    logic              d_bad;
    logic [AWIDTH:0]   addr_ext;

    // Arbitration: data wins unless it is idle or fetch has starved long enough;
    // nothing is granted until one clock edge has passed since reset release.
    always_comb begin
        fetch_win = ready_q && if_req_i && (!d_req_i || (starve_q == STARVE_LIM));
        data_win  = ready_q && d_req_i && !fetch_win;
    end

    // Classify the data request: misaligned halfword/word or outside the
    // memory window. An unknown address is passed through as a harmless
    // no-op with zero read data and no error.
    always_comb begin
        if_addr_x    = $isunknown(if_addr_i);
        d_addr_x     = $isunknown(d_addr_i);
        addr_ext     = {1'b0, d_addr_i};
        misaligned   = ((d_funct3_i[1:0] == 2'b01) && d_addr_i[0]) ||
                       ((d_funct3_i[1:0] == 2'b10) && (d_addr_i[1:0] != 2'b00));
        out_of_range = (addr_ext < BASE_EXT) ||
                       ((addr_ext + (AWIDTH+1)'(3)) >= END_EXT);
        d_bad        = !d_addr_x && (misaligned || out_of_range);
    end

    // Memory port steering: fetch reads a word; data passes its request
    // through; errored or idle cycles leave every memory output at zero.
    always_comb begin
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_funct3_o = 3'b000;
        mem_ren_o    = 1'b0;
        mem_wen_o    = 1'b0;
        if (fetch_win && !if_addr_x) begin
            mem_addr_o   = if_addr_i;
            mem_funct3_o = 3'b010;
            mem_ren_o    = 1'b1;
        end else if (data_win && !d_addr_x && !d_bad) begin
            mem_addr_o   = d_addr_i;
            mem_funct3_o = d_funct3_i;
            mem_wdata_o  = d_wdata_i;
            mem_ren_o    = !d_we_i;
            mem_wen_o    = d_we_i;
        end
    end

    // Next-state: starvation/stall counters and the one-cycle-late responses.
    // Read data is held when no response is due.
    always_comb begin
        ready_d  = 1'b1;
        starve_d = '0;
        stall_d  = stall_q;
        if (if_req_i && !fetch_win) begin
            starve_d = starve_q;
            if (starve_q != STARVE_LIM) begin
                starve_d = starve_q + SW'(1);
                if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
            end
        end

        if_rvalid_d = fetch_win;
        if_rdata_d  = if_rdata_q;
        if (fetch_win) begin
            if_rdata_d = if_addr_x ? '0 : mem_rdata_i;
        end

        d_rvalid_d = data_win;
        d_err_d    = data_win && d_bad;
        d_rdata_d  = d_rdata_q;
        if (data_win) begin
            d_rdata_d = (d_bad || d_we_i || d_addr_x) ? '0 : mem_rdata_i;
        end
    end

    // State registers; reset clears everything, including any pending response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q     <= 1'b0;
            starve_q    <= '0;
            stall_q     <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            ready_q     <= ready_d;
            starve_q    <= starve_d;
            stall_q     <= stall_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_gnt_o       = fetch_win;
    assign d_gnt_o        = data_win;
    assign if_rvalid_o    = if_rvalid_q;
    assign if_rdata_o     = if_rdata_q;
    assign d_rvalid_o     = d_rvalid_q;
    assign d_err_o        = d_err_q;
    assign d_rdata_o      = d_rdata_q;
    assign if_stall_cnt_o = stall_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a memory fixture, a
// per-cycle reference model of the arbitration rules and literal checks.

module tb_mem_arbiter;

    localparam logic [31:0] BASE   = 32'h0100_0000;
    localparam logic [31:0] MEMB   = 32'h0000_1000;
    localparam int          STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_funct3;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_rdata;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .MEM_BYTES(MEMB), .STARVE_MAX(STARVE)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_funct3_i(d_funct3), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
        .d_rdata_o(d_rdata), .d_err_o(d_err),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_funct3_o(mem_funct3),
        .mem_ren_o(mem_ren), .mem_wen_o(mem_wen), .mem_rdata_i(mem_rdata),
        .if_stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    // Memory fixture: 4 KB window at BASE, combinational read, write on clock edge.
    logic [31:0] fmem [0:1023];
    logic        floaded = 1'b0;
    int          wr_count = 0;
    logic [31:0] foff;
    logic        fin_win;
    assign foff      = mem_addr - BASE;
    assign fin_win   = (mem_addr >= BASE) && (mem_addr < BASE + MEMB);
    assign mem_rdata = fin_win ? fmem[foff[11:2]] : 32'h0;

    always @(posedge clk) begin
        if (!floaded) begin
            for (int i = 0; i < 1024; i++) fmem[i] <= 32'h0;
            fmem[0]    <= 32'h0050_0093;
            fmem[1]    <= 32'h00A0_0113;
            fmem[1023] <= 32'hCAFE_F00D;
            floaded    <= 1'b1;
        end else if (mem_wen) begin
            wr_count <= wr_count + 1;
            if (fin_win) fmem[foff[11:2]] <= mem_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] mmem [0:1023];
    bit          m_init = 1'b0;
    bit          m_ready;
    int          m_starve, m_stall;
    bit          e_if_rv, e_d_rv, e_d_err;
    logic [31:0] e_if_rd, e_d_rd;

    function automatic bit model_err(input logic [31:0] a, input logic [2:0] f3);
        longint la = longint'(a);
        bit mis = (f3[1:0] == 2'b01 && (a % 2) != 0) || (f3[1:0] == 2'b10 && (a % 4) != 0);
        bit oor = (la < longint'(BASE)) || (la + 3 >= longint'(BASE) + longint'(MEMB));
        return mis || oor;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off = a - BASE;
        if (a >= BASE && a < BASE + MEMB) return mmem[off[11:2]];
        return 32'h0;
    endfunction

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        bit          eg_f, eg_d, err;
        logic [31:0] ea, ew, off;
        logic [2:0]  ef;
        bit          er, ewn;
        if (!m_init) begin
            for (int i = 0; i < 1024; i++) mmem[i] = 32'h0;
            mmem[0] = 32'h0050_0093; mmem[1] = 32'h00A0_0113; mmem[1023] = 32'hCAFE_F00D;
            m_init = 1'b1;
        end
        if (!rst) begin
            checkOutput("rst if_gnt", {31'b0, if_gnt}, 32'h0);
            checkOutput("rst d_gnt", {31'b0, d_gnt}, 32'h0);
            checkOutput("rst if_rvalid", {31'b0, if_rvalid}, 32'h0);
            checkOutput("rst d_rvalid", {31'b0, d_rvalid}, 32'h0);
            checkOutput("rst d_err", {31'b0, d_err}, 32'h0);
            checkOutput("rst if_rdata", if_rdata, 32'h0);
            checkOutput("rst d_rdata", d_rdata, 32'h0);
            checkOutput("rst stall", {16'b0, stall_cnt}, 32'h0);
            checkOutput("rst mem", {mem_addr | mem_wdata} | {27'b0, mem_funct3, mem_ren, mem_wen}, 32'h0);
            m_ready = 0; m_starve = 0; m_stall = 0;
            e_if_rv = 0; e_d_rv = 0; e_d_err = 0; e_if_rd = 0; e_d_rd = 0;
        end else begin
            eg_f = m_ready && if_req && (!d_req || m_starve == STARVE);
            eg_d = m_ready && d_req && !eg_f;
            err  = model_err(d_addr, d_funct3);
            ea = 0; ew = 0; ef = 0; er = 0; ewn = 0;
            if (eg_f) begin
                ea = if_addr; ef = 3'b010; er = 1;
            end else if (eg_d && !err) begin
                ea = d_addr; ef = d_funct3; ew = d_wdata; er = !d_we; ewn = d_we;
            end
            checkOutput("m if_gnt", {31'b0, if_gnt}, {31'b0, eg_f});
            checkOutput("m d_gnt", {31'b0, d_gnt}, {31'b0, eg_d});
            checkOutput("m mem_addr", mem_addr, ea);
            checkOutput("m mem_funct3", {29'b0, mem_funct3}, {29'b0, ef});
            checkOutput("m mem_ren", {31'b0, mem_ren}, {31'b0, er});
            checkOutput("m mem_wen", {31'b0, mem_wen}, {31'b0, ewn});
            if (!eg_f) checkOutput("m mem_wdata", mem_wdata, ew);
            checkOutput("m if_rvalid", {31'b0, if_rvalid}, {31'b0, e_if_rv});
            checkOutput("m if_rdata", if_rdata, e_if_rd);
            checkOutput("m d_rvalid", {31'b0, d_rvalid}, {31'b0, e_d_rv});
            if (e_d_rv) checkOutput("m d_err", {31'b0, d_err}, {31'b0, e_d_err});
            checkOutput("m d_rdata", d_rdata, e_d_rd);
            checkOutput("m stall", {16'b0, stall_cnt}, m_stall);

            if (if_req && !eg_f) begin
                if (m_starve < STARVE) begin
                    m_starve++;
                    if (m_stall < 65535) m_stall++;
                end
            end else begin
                m_starve = 0;
            end
            e_if_rv = eg_f;
            if (eg_f) e_if_rd = model_read(if_addr);
            e_d_rv  = eg_d;
            e_d_err = eg_d && err;
            if (eg_d) e_d_rd = (err || d_we) ? 32'h0 : model_read(d_addr);
            if (eg_d && d_we && !err) begin
                off = d_addr - BASE;
                mmem[off[11:2]] = d_wdata;
            end
            m_ready = 1;
        end
    end

    // Drive one cycle of inputs just after the clock edge, then move to mid-cycle.
    task automatic applyStimulus(input bit fr, input logic [31:0] fa, input bit dr,
                                 input bit we, input logic [31:0] da,
                                 input logic [31:0] wd, input logic [2:0] f3);
        @(posedge clk);
        #1;
        if_req = fr; if_addr = fa; d_req = dr; d_we = we;
        d_addr = da; d_wdata = wd; d_funct3 = f3;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 3'b000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [9:0] f_pat, d_pat;
        logic [15:0] stall5;
        int wr_before;
        rst = 1'b0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_funct3 = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset stall", {16'b0, stall_cnt}, 32'h0);
        @(posedge clk); #1 rst = 1'b1;

        // Fetch-only
        applyStimulus(1, BASE, 0, 0, 32'h0, 32'h0, 3'b000);
        checkOutput("fetch gnt", {31'b0, if_gnt}, 32'h1);
        checkOutput("fetch mem_addr", mem_addr, 32'h0100_0000);
        idle();
        checkOutput("fetch rvalid", {31'b0, if_rvalid}, 32'h1);
        checkOutput("fetch rdata", if_rdata, 32'h0050_0093);
        idle();
        checkOutput("fetch hold rdata", if_rdata, 32'h0050_0093);

        // Store/load round trip
        applyStimulus(0, 0, 1, 1, 32'h0100_0100, 32'hDEAD_BEEF, 3'b010);
        checkOutput("sw wen", {31'b0, mem_wen}, 32'h1);
        applyStimulus(0, 0, 1, 0, 32'h0100_0100, 32'h0, 3'b010);
        checkOutput("sw rvalid", {31'b0, d_rvalid}, 32'h1);
        checkOutput("sw rdata", d_rdata, 32'h0);
        idle();
        checkOutput("lw rdata", d_rdata, 32'hDEAD_BEEF);
        checkOutput("lw err", {31'b0, d_err}, 32'h0);

        // Misaligned word load
        applyStimulus(0, 0, 1, 0, 32'h0100_0102, 32'h0, 3'b010);
        checkOutput("mis gnt", {31'b0, d_gnt}, 32'h1);
        checkOutput("mis ren", {31'b0, mem_ren}, 32'h0);
        idle();
        checkOutput("mis err", {31'b0, d_err}, 32'h1);
        checkOutput("mis rdata", d_rdata, 32'h0);

        // Out-of-range store
        wr_before = wr_count;
        applyStimulus(0, 0, 1, 1, 32'h00FF_FFFC, 32'h1234_5678, 3'b010);
        checkOutput("oor wen", {31'b0, mem_wen}, 32'h0);
        idle();
        checkOutput("oor err", {31'b0, d_err}, 32'h1);
        checkOutput("oor no write", wr_count, wr_before);

        // Window boundaries and sub-word sizes, back to back
        applyStimulus(0, 0, 1, 0, 32'h0100_0FFC, 32'h0, 3'b010);
        applyStimulus(0, 0, 1, 0, 32'h0100_1000, 32'h0, 3'b010);
        checkOutput("last word err", {31'b0, d_err}, 32'h0);
        checkOutput("last word rdata", d_rdata, 32'hCAFE_F00D);
        applyStimulus(0, 0, 1, 0, 32'h0100_0001, 32'h0, 3'b001);
        checkOutput("end err", {31'b0, d_err}, 32'h1);
        applyStimulus(0, 0, 1, 0, 32'h0100_0003, 32'h0, 3'b100);
        checkOutput("lh odd err", {31'b0, d_err}, 32'h1);
        idle();
        checkOutput("lbu odd err", {31'b0, d_err}, 32'h0);
        checkOutput("lbu rdata", d_rdata, 32'h0050_0093);

        // Contention
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, BASE + 32'h4, 1, 0, BASE, 32'h0, 3'b010);
            f_pat[i] = if_gnt;
            d_pat[i] = d_gnt;
            if (i == 5) stall5 = stall_cnt;
        end
        checkOutput("contend fetch pattern", {22'b0, f_pat}, 32'h210);
        checkOutput("contend data pattern", {22'b0, d_pat}, 32'h1EF);
        checkOutput("contend stall after 5", {16'b0, stall5}, 32'h4);
        idle();
        checkOutput("contend stall after 10", {16'b0, stall_cnt}, 32'h8);
        checkOutput("contend fetch rdata", if_rdata, 32'h00A0_0113);

        // Reset mid-operation
        applyStimulus(0, 0, 1, 0, BASE + 32'h4, 32'h0, 3'b010);
        checkOutput("rmid gnt", {31'b0, d_gnt}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0; d_req = 0;
        @(negedge clk);
        checkOutput("rmid rvalid", {31'b0, d_rvalid}, 32'h0);
        checkOutput("rmid stall", {16'b0, stall_cnt}, 32'h0);
        checkOutput("rmid if_rdata", if_rdata, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1; d_we = 0; d_addr = BASE; d_funct3 = 3'b010;
        @(negedge clk);
        checkOutput("post-rst first gnt", {31'b0, d_gnt}, 32'h0);
        @(negedge clk);
        checkOutput("post-rst second gnt", {31'b0, d_gnt}, 32'h1);
        checkOutput("post-rst no ghost", {31'b0, d_rvalid}, 32'h0);
        idle();
        checkOutput("post-rst rdata", d_rdata, 32'h0050_0093);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
